ryu_action_ctrl: RTL and testbench

- Per-fighter action sequencer that drives the `sprite` select (3-bit) and the RyuX/RyuY position consumed by the Ryu sprite mux and renderer.
- Converts decoded player button levels into timed actions: stand, punch, jump with gravity, crouch, walk left, walk right.
- All state advances once per frame on a one-cycle frame_tick strobe in the vga_clk domain.
- The VGA path samples RyuX, RyuY and sprite directly.

---
 rtl/ryu_action_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_ryu_action_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ryu_action_ctrl.sv
// Purpose : per-fighter action sequencer (stand/punch/jump/crouch/walk) driving the Ryu sprite pose and anchor.
// Latency : buttons sampled on a frame_tick edge appear on RyuX/RyuY/sprite/busy right after that edge.
// Backpr. : none; free-running, advances only on frame_tick, holds otherwise. PUNCH and JUMP ignore buttons.
//
// Ports: vga_clk, Reset (sync, active-high), frame_tick (1-cycle strobe per frame),
//        btn_left/right/jump/punch/crouch (levels), RyuX/RyuY (10-bit anchor),
//        sprite (pose code = state code), busy (high in PUNCH/JUMP).
// Optional: define PUNCH_COOLDOWN_EN to lock out punches for COOLDOWN_FRAMES ticks after each punch.
module ryu_action_ctrl #(
    parameter int X_START      = 100,
    parameter int GROUND_Y     = 300,
    parameter int X_MIN        = 0,
    parameter int X_MAX        = 560,
    parameter int WALK_STEP    = 2,
    parameter int PUNCH_FRAMES = 12,
    parameter int JUMP_V       = 12,
    parameter int GRAVITY      = 1
`ifdef PUNCH_COOLDOWN_EN
   ,parameter int COOLDOWN_FRAMES = 8
`endif
) (
    input  logic       vga_clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    input  logic       btn_punch,
    input  logic       btn_crouch,
    output logic [9:0] RyuX,
    output logic [9:0] RyuY,
    output logic [2:0] sprite,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_STAND  = 3'd0,
        ST_PUNCH  = 3'd1,
        ST_JUMP   = 3'd2,
        ST_CROUCH = 3'd3,
        ST_WALK_L = 3'd4,
        ST_WALK_R = 3'd5
    } state_t;

    // Sized copies of the parameters so all position math is 12-bit signed.
    localparam logic signed [11:0] XMIN_S  = 12'(X_MIN);
    localparam logic signed [11:0] XMAX_S  = 12'(X_MAX);
    localparam logic signed [11:0] STEP_S  = 12'(WALK_STEP);
    localparam logic signed [11:0] GY_S    = 12'(GROUND_Y);
    localparam logic signed [7:0]  JV_S    = 8'(JUMP_V);
    localparam logic signed [7:0]  GRAV_S  = 8'(GRAVITY);
    localparam logic [7:0]         PCNT_LD = 8'(PUNCH_FRAMES - 1);
`ifdef PUNCH_COOLDOWN_EN
    localparam logic [7:0]         COOL_LD = 8'(COOLDOWN_FRAMES);
`endif

    state_t             state;
    logic signed [7:0]  vy;
    logic signed [1:0]  drift;
    logic [7:0]         punch_cnt;
`ifdef PUNCH_COOLDOWN_EN
    logic [7:0]         cooldown;
`endif

    // Next-position helpers
    logic signed [7:0]  vy_use;
    logic signed [1:0]  drift_use;
    logic signed [11:0] dx_drift;
    logic signed [11:0] y_next;
    logic               land;
    logic [9:0]         x_drift;
    logic [9:0]         x_left;
    logic [9:0]         x_right;
    logic               punch_ok;

    // Move x by dx and saturate to [X_MIN, X_MAX]; the extra bits catch underflow.
    function automatic logic [9:0] clamp_x(input logic [9:0] x, input logic signed [11:0] dx);
        logic signed [11:0] s;
        s = $signed({2'b00, x}) + dx;
        if (s < XMIN_S)
            clamp_x = XMIN_S[9:0];
        else if (s > XMAX_S)
            clamp_x = XMAX_S[9:0];
        else
            clamp_x = s[9:0];
    endfunction

    assign sprite = state;

`ifdef PUNCH_COOLDOWN_EN
    assign punch_ok = btn_punch && (cooldown == 8'd0);
`else
    assign punch_ok = btn_punch;
`endif

    always_comb begin
        // Outside JUMP these describe the entry step, taken on the same tick.
        vy_use    = (state == ST_JUMP) ? vy : JV_S;
        drift_use = 2'sd0;
        if (state == ST_JUMP)
            drift_use = drift;
        else if (btn_left)
            drift_use = -2'sd1;
        else if (btn_right)
            drift_use = 2'sd1;
        dx_drift = 12'sd0;
        if (drift_use == -2'sd1)
            dx_drift = -STEP_S;
        else if (drift_use == 2'sd1)
            dx_drift = STEP_S;
        // Screen y grows downward, so upward velocity subtracts.
        y_next  = $signed({2'b00, RyuY}) - {{4{vy_use[7]}}, vy_use};
        land    = vy_use[7] && (y_next >= GY_S);
        x_drift = clamp_x(RyuX, dx_drift);
        x_left  = clamp_x(RyuX, -STEP_S);
        x_right = clamp_x(RyuX, STEP_S);
    end

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            state     <= ST_STAND;
            RyuX      <= 10'(X_START);
            RyuY      <= 10'(GROUND_Y);
            busy      <= 1'b0;
            vy        <= 8'sd0;
            drift     <= 2'sd0;
            punch_cnt <= 8'd0;
`ifdef PUNCH_COOLDOWN_EN
            cooldown  <= 8'd0;
`endif
        end else if (frame_tick) begin
`ifdef PUNCH_COOLDOWN_EN
            if (cooldown != 8'd0)
                cooldown <= cooldown - 8'd1;
`endif
            case (state)
                ST_STAND, ST_CROUCH, ST_WALK_L, ST_WALK_R: begin
                    if (btn_jump) begin
                        // Launch: first motion step applied on the entry tick.
                        state <= ST_JUMP;
                        busy  <= 1'b1;
                        drift <= drift_use;
                        RyuY  <= y_next[9:0];
                        vy    <= vy_use - GRAV_S;
                        RyuX  <= x_drift;
                    end else if (punch_ok) begin
                        state     <= ST_PUNCH;
                        busy      <= 1'b1;
                        punch_cnt <= PCNT_LD;
                    end else if (btn_crouch) begin
                        state <= ST_CROUCH;
                        busy  <= 1'b0;
                    end else if (btn_left) begin
                        state <= ST_WALK_L;
                        busy  <= 1'b0;
                        RyuX  <= x_left;
                    end else if (btn_right) begin
                        state <= ST_WALK_R;
                        busy  <= 1'b0;
                        RyuX  <= x_right;
                    end else begin
                        state <= ST_STAND;
                        busy  <= 1'b0;
                    end
                end
                ST_PUNCH: begin
                    // Counter loaded with N-1 on entry, so the pose lasts N ticks.
                    if (punch_cnt == 8'd0) begin
                        state <= ST_STAND;
                        busy  <= 1'b0;
`ifdef PUNCH_COOLDOWN_EN
                        cooldown <= COOL_LD;
`endif
                    end else begin
                        punch_cnt <= punch_cnt - 8'd1;
                    end
                end
                ST_JUMP: begin
                    if (land) begin
                        RyuY  <= GY_S[9:0];
                        state <= ST_STAND;
                        busy  <= 1'b0;
                    end else begin
                        RyuY <= y_next[9:0];
                    end
                    vy   <= vy_use - GRAV_S;
                    RyuX <= x_drift;
                end
                default: begin
                    state <= ST_STAND;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ryu_action_ctrl.sv
module tb_ryu_action_ctrl;

    logic       vga_clk = 1'b0;
    logic       Reset;
    logic       frame_tick;
    logic       btn_left, btn_right, btn_jump, btn_punch, btn_crouch;
    logic [9:0] RyuX, RyuY;
    logic [2:0] sprite;
    logic       busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      tag;
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] spr;
        logic       bsy;
    } exp_t;

    exp_t sb[$];

    ryu_action_ctrl dut (
        .vga_clk    (vga_clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_jump   (btn_jump),
        .btn_punch  (btn_punch),
        .btn_crouch (btn_crouch),
        .RyuX       (RyuX),
        .RyuY       (RyuY),
        .sprite     (sprite),
        .busy       (busy)
    );

    always #5 vga_clk = ~vga_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Closed-form jump height after k ticks with the default parameters.
    function automatic int jump_y(input int k);
        if (k <= 12)
            return 300 - (12 * k - (k * (k - 1)) / 2);
        else if (k < 25)
            return 222 + ((k - 13) * (k - 12)) / 2;
        else
            return 300;
    endfunction

    task automatic push(input string tag, input int x, input int y, input int spr, input bit b);
        exp_t e;
        e.tag = tag;
        e.x   = 10'(x);
        e.y   = 10'(y);
        e.spr = 3'(spr);
        e.bsy = b;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got no entry, want one");
            return;
        end
        e = sb.pop_front();
        checks++;
        assert (RyuX === e.x) else begin
            errors++;
            $error("FAIL %s RyuX: got %0d want %0d", e.tag, RyuX, e.x);
        end
        checks++;
        assert (RyuY === e.y) else begin
            errors++;
            $error("FAIL %s RyuY: got %0d want %0d", e.tag, RyuY, e.y);
        end
        checks++;
        assert (sprite === e.spr) else begin
            errors++;
            $error("FAIL %s sprite: got %0d want %0d", e.tag, sprite, e.spr);
        end
        checks++;
        assert (busy === e.bsy) else begin
            errors++;
            $error("FAIL %s busy: got %0b want %0b", e.tag, busy, e.bsy);
        end
    endtask

    task automatic set_btn(input bit l, input bit r, input bit j, input bit p, input bit c);
        btn_left   = l;
        btn_right  = r;
        btn_jump   = j;
        btn_punch  = p;
        btn_crouch = c;
    endtask

    // One frame tick: inputs driven 1 time unit after an edge, outputs sampled 1 unit after the next.
    task automatic step(input string tag, input bit l, input bit r, input bit j, input bit p, input bit c,
                        input int ex, input int ey, input int espr, input bit eb);
        push(tag, ex, ey, espr, eb);
        set_btn(l, r, j, p, c);
        frame_tick = 1'b1;
        @(posedge vga_clk);
        #1;
        frame_tick = 1'b0;
        pop_check();
    endtask

    task automatic reset_check(input string tag, input int cycles);
        push(tag, 100, 300, 0, 1'b0);
        Reset = 1'b1;
        set_btn(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        frame_tick = 1'($urandom);
        repeat (cycles) @(posedge vga_clk);
        #1;
        Reset = 1'b0;
        frame_tick = 1'b0;
        set_btn(0, 0, 0, 0, 0);
        pop_check();
    endtask

    initial begin
        int x;
        int stand_ticks;
        Reset = 1'b1;
        frame_tick = 1'b0;
        set_btn(0, 0, 0, 0, 0);
        #1;

        // Reset with random buttons, then idle ticks hold everything.
        reset_check("reset", 2);
        for (int k = 1; k <= 5; k++)
            step("idle", 0, 0, 0, 0, 0, 100, 300, 0, 1'b0);

        // Walk right 10 ticks, then left+right resolves to left.
        for (int k = 1; k <= 10; k++)
            step("walk_r", 0, 1, 0, 0, 0, 100 + 2 * k, 300, 5, 1'b0);
        for (int k = 1; k <= 3; k++)
            step("both_lr", 1, 1, 0, 0, 0, 120 - 2 * k, 300, 4, 1'b0);

        // Left edge: 114 -> 2, then saturate at 0.
        for (int k = 1; k <= 56; k++)
            step("walk_l", 1, 0, 0, 0, 0, 114 - 2 * k, 300, 4, 1'b0);
        for (int k = 1; k <= 5; k++)
            step("clamp_min", 1, 0, 0, 0, 0, 0, 300, 4, 1'b0);

        // Right edge: 0 -> 560, then saturate.
        for (int k = 1; k <= 280; k++)
            step("walk_r_far", 0, 1, 0, 0, 0, 2 * k, 300, 5, 1'b0);
        for (int k = 1; k <= 5; k++)
            step("clamp_max", 0, 1, 0, 0, 0, 560, 300, 5, 1'b0);
        step("stand_560", 0, 0, 0, 0, 0, 560, 300, 0, 1'b0);

        // Punch for exactly 12 ticks; jump held meanwhile is only taken after one STAND tick.
        step("punch_1", 0, 0, 0, 1, 0, 560, 300, 1, 1'b1);
        for (int k = 2; k <= 12; k++)
            step("punch_hold", 0, 0, 1, 0, 0, 560, 300, 1, 1'b1);
        step("punch_end", 0, 0, 1, 0, 0, 560, 300, 0, 1'b0);
        step("jump_after_punch", 0, 0, 1, 0, 0, 560, jump_y(1), 2, 1'b1);
        for (int k = 2; k <= 25; k++)
            step("jump_nodrift", 0, 0, 0, 0, 0, 560, jump_y(k), (k < 25) ? 2 : 0, k < 25);

        // Jump with right drift from X_START: apex 222 at tick 12, land at 300 on tick 25, x = 150.
        reset_check("reset_pre_jump", 1);
        step("jump_r_1", 0, 1, 1, 0, 0, 102, jump_y(1), 2, 1'b1);
        for (int k = 2; k <= 25; k++)
            step("jump_r", 0, 0, 0, 0, 0, 100 + 2 * k, jump_y(k), (k < 25) ? 2 : 0, k < 25);

        // Reset in the middle of a jump.
        step("jump2_1", 0, 0, 1, 0, 0, 150, jump_y(1), 2, 1'b1);
        for (int k = 2; k <= 7; k++)
            step("jump2", 0, 0, 0, 0, 0, 150, jump_y(k), 2, 1'b1);
        reset_check("reset_midjump", 1);
        step("after_reset", 0, 0, 0, 0, 0, 100, 300, 0, 1'b0);

        // Crouch holds position and beats walking; leaving crouch on first low tick.
        step("crouch", 0, 0, 0, 0, 1, 100, 300, 3, 1'b0);
        step("crouch_l", 1, 0, 0, 0, 1, 100, 300, 3, 1'b0);
        step("uncrouch_l", 1, 0, 0, 0, 0, 98, 300, 4, 1'b0);

        // No frame_tick: nothing moves even with a button held.
        push("no_tick", 98, 300, 4, 1'b0);
        set_btn(0, 1, 0, 0, 0);
        frame_tick = 1'b0;
        repeat (4) @(posedge vga_clk);
        #1;
        pop_check();

        // Held punch: 12 punch ticks, a STAND gap, then a fresh punch.
`ifdef PUNCH_COOLDOWN_EN
        stand_ticks = 1 + 8;
`else
        stand_ticks = 1;
`endif
        x = 98;
        for (int k = 1; k <= 12; k++)
            step("held_punch", 0, 0, 0, 1, 0, x, 300, 1, 1'b1);
        for (int k = 1; k <= stand_ticks; k++)
            step("held_gap", 0, 0, 0, 1, 0, x, 300, 0, 1'b0);
        step("held_refire", 0, 0, 0, 1, 0, x, 300, 1, 1'b1);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
